blink_decoder: RTL and testbench
================================

# blink_decoder

Measures a received blink waveform (the pattern produced by the team's LED blinker: 1 s period, 0.5 s or 0.25 s high time) and classifies each complete period as LONG, SHORT or invalid. Sits on the sensor/debug input side of the line follower, e.g. reading a status blink from a second board. Reports one result per period with a validity pulse and a lock indication.

## Interface
- `PERIOD`, 100_000_000: nominal period in clk cycles.
- `LONG_HIGH`, 50_000_000: nominal high time of a long blink, in cycles.
- `SHORT_HIGH`, 25_000_000: nominal high time of a short blink, in cycles.
- `TOL`, 1_000_000: allowed ± deviation in cycles for every comparison.
- `LOCK_N`, 2: consecutive identical valid classifications needed to assert `locked`.
- `FILTER_LEN`, 16: stability length in cycles; used only with the glitch filter.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `blink_in`  in  1  asynchronous blink waveform.
- `valid`  out  1  one-cycle pulse: period measured, `is_short`/`err` updated.
- `is_short`  out  1  1 = last good period was SHORT, 0 = LONG; held between pulses.
- `err`  out  1  one-cycle pulse: period or high time out of tolerance, or timeout.
- `locked`  out  1  high while last `LOCK_N` classifications were valid and identical.

## Operation
- `blink_in` passes through a 2-flop synchronizer, then edge detection on the synchronized value.
- Counter width: ceil(log2(PERIOD+TOL+2)) bits (27 for defaults); saturates, never wraps.
- States:
  - IDLE (reset): wait for first synced rising edge -> HIGH, counters cleared to 1.
  - HIGH: increment `hi_cnt` and `per_cnt`; falling edge -> LOW.
  - LOW: increment `per_cnt`; rising edge -> evaluate, restart both counters at 1, -> HIGH.
  - Timeout: `per_cnt` > PERIOD+TOL in HIGH or LOW -> `err` pulse, `locked`=0, streak cleared, -> IDLE.
- Evaluation on closing rising edge (bounds inclusive):
  - `per_cnt` within PERIOD±TOL and `hi_cnt` within SHORT_HIGH±TOL -> `valid`, `is_short`=1.
  - Same period, `hi_cnt` within LONG_HIGH±TOL -> `valid`, `is_short`=0.
  - Otherwise -> `valid` and `err` together; `is_short` unchanged; streak cleared; `locked`=0.
- Streak counter: +1 per good classification equal to previous; reset to 1 on class change; `locked`=1 once streak ≥ LOCK_N, stays set until err/timeout/class change.
- Constant input (stuck high or low) always ends in timeout; no `valid` without two rising edges.
- Reset mid-period: all state cleared immediately; partial period discarded.

## Timing
- Reset values: `valid`=0, `err`=0, `is_short`=0, `locked`=0, state IDLE, counters 0, synchronizer flops 0.
- Latency: raw rising edge on cycle t -> `valid`/`err` registered high on cycle t+3 (2 sync + 1 edge/evaluate register).
- `hi_cnt` equals the number of cycles the raw input was high (sync delay cancels).
- `valid` and `err` are single-cycle; `is_short` and `locked` update the same cycle as `valid`.
- Timeout `err` fires the cycle after `per_cnt` reaches PERIOD+TOL+1.

## Configuration
- `BLINK_DECODER_GLITCH_FILTER_EN` defined: after the synchronizer, a level changes only after the new value is stable for FILTER_LEN consecutive cycles; shorter pulses ignored; latency becomes t+3+FILTER_LEN; measured widths unchanged for clean input.
- Undefined: no filter; every synced edge counts; a 1-cycle glitch in HIGH ends the high phase.

## Test plan
Use PERIOD=100, LONG_HIGH=50, SHORT_HIGH=25, TOL=2, LOCK_N=2, FILTER_LEN=4.
- Four periods of 25 high/75 low -> `valid` pulses at each closing edge (3 cycles after raw edge), `is_short`=1, `locked` high from the 2nd `valid`.
- 50/50 periods then switch to 25/75 -> `is_short` 0 then 1; `locked` drops on change, re-asserts after 2nd SHORT.
- Period 103 (hi 50) -> `valid`+`err` same cycle, `locked`=0; period 102 -> accepted (inclusive bound).
- Input held high 200 cycles after a rising edge -> single `err` at `per_cnt`=103, state IDLE, no `valid`.
- 1-cycle low glitch inside a 50-cycle high: macro off -> `err` on evaluation; macro on -> LONG accepted.
- `rst` low mid-HIGH for 1 cycle -> all outputs 0 immediately; next good period needs 2 rising edges before `valid`.

Source files
------------

// File: rtl/blink_decoder.sv
// -----------------------------------------------------------------------------
// blink_decoder
//
// Measures a received blink waveform (nominal 1 s period with either a long
// or a short high time) and classifies every complete period, closed by the
// next rising edge, as LONG, SHORT or invalid.
//
// Optional feature macro: BLINK_DECODER_GLITCH_FILTER_EN
//   Defined   -> the synchronized input only changes level after the new value
//                has been stable for FILTER_LEN consecutive cycles.
//   Undefined -> every synchronized edge is used directly.
//
// Parameters (all in clk cycles except LOCK_N):
//   PERIOD      nominal period
//   LONG_HIGH   nominal high time of a LONG blink
//   SHORT_HIGH  nominal high time of a SHORT blink
//   TOL         inclusive +/- tolerance for every comparison
//   LOCK_N      identical valid classifications needed for `locked`
//   FILTER_LEN  stability length of the glitch filter
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   blink_in  in   asynchronous blink waveform
//   valid     out  one-cycle pulse: a period was measured
//   is_short  out  class of the last good period (1 = SHORT, 0 = LONG), held
//   err       out  one-cycle pulse: out-of-tolerance period/high time or timeout
//   locked    out  high while the last LOCK_N classifications were valid and equal
// -----------------------------------------------------------------------------
module blink_decoder #(
    parameter int unsigned PERIOD     = 100_000_000,
    parameter int unsigned LONG_HIGH  = 50_000_000,
    parameter int unsigned SHORT_HIGH = 25_000_000,
    parameter int unsigned TOL        = 1_000_000,
    parameter int unsigned LOCK_N     = 2,
    parameter int unsigned FILTER_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic blink_in,
    output logic valid,
    output logic is_short,
    output logic err,
    output logic locked
);

`ifdef BLINK_DECODER_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // Counters must hold PERIOD+TOL+1, the value that triggers the timeout.
    localparam int unsigned CW = $clog2(PERIOD + TOL + 2);
    localparam int unsigned SW = $clog2(LOCK_N + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] PER_MIN  = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] PER_MAX  = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] SHORT_LO = CW'(SHORT_HIGH - TOL);
    localparam logic [CW-1:0] SHORT_HI = CW'(SHORT_HIGH + TOL);
    localparam logic [CW-1:0] LONG_LO  = CW'(LONG_HIGH - TOL);
    localparam logic [CW-1:0] LONG_HI  = CW'(LONG_HIGH + TOL);
    localparam logic [SW-1:0] STK_ONE  = SW'(1);
    localparam logic [SW-1:0] LOCK_LVL = SW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] hi_cnt, hi_cnt_n;
    logic [CW-1:0] per_cnt, per_cnt_n;
    logic [SW-1:0] streak, streak_n;
    logic          valid_n, err_n, is_short_n, locked_n;

    logic sync1, sync2;
    logic level, level_d;
    logic rise, fall;
    logic period_ok, short_ok, long_ok;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Two-flop synchronizer for the asynchronous input.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= blink_in;
            sync2 <= sync1;
        end
    end

    generate
        if (FILTER_EN && (FILTER_LEN > 0)) begin : g_filter
            localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
            localparam logic [FW-1:0] LAST = FW'(FILTER_LEN - 1);

            logic [FW-1:0] stable_cnt;
            logic          filt;

            // Counts consecutive cycles where the input disagrees with the
            // filtered level; any agreement restarts the count. Both edges are
            // delayed equally, so clean widths are preserved.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    filt       <= 1'b0;
                    stable_cnt <= '0;
                end else if (sync2 == filt) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == LAST) begin
                    filt       <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + FW'(1);
                end
            end

            assign level = filt;
        end else begin : g_nofilter
            assign level = sync2;
        end
    endgenerate

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    // Inclusive tolerance windows, evaluated on the closing rising edge.
    assign period_ok = (per_cnt >= PER_MIN)  && (per_cnt <= PER_MAX);
    assign short_ok  = (hi_cnt  >= SHORT_LO) && (hi_cnt  <= SHORT_HI);
    assign long_ok   = (hi_cnt  >= LONG_LO)  && (hi_cnt  <= LONG_HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            streak   <= '0;
            level_d  <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            is_short <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_n;
            hi_cnt   <= hi_cnt_n;
            per_cnt  <= per_cnt_n;
            streak   <= streak_n;
            level_d  <= level;
            valid    <= valid_n;
            err      <= err_n;
            is_short <= is_short_n;
            locked   <= locked_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so no
        // path leaves a variable unassigned, which would infer a latch.
        state_n    = state;
        hi_cnt_n   = hi_cnt;
        per_cnt_n  = per_cnt;
        streak_n   = streak;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        is_short_n = is_short;
        locked_n   = locked;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_n   = HIGH;
                    hi_cnt_n  = CNT_ONE;
                    per_cnt_n = CNT_ONE;
                end
            end

            HIGH: begin
                if (per_cnt > PER_MAX) begin
                    state_n   = IDLE;
                    hi_cnt_n  = '0;
                    per_cnt_n = '0;
                    err_n     = 1'b1;
                    streak_n  = '0;
                    locked_n  = 1'b0;
                end else if (fall) begin
                    state_n   = LOW;
                    per_cnt_n = sat_inc(per_cnt);
                end else begin
                    hi_cnt_n  = sat_inc(hi_cnt);
                    per_cnt_n = sat_inc(per_cnt);
                end
            end

            LOW: begin
                // A closing edge is evaluated even when it coincides with the
                // timeout threshold; the evaluation reports the error itself.
                if (rise) begin
                    state_n   = HIGH;
                    hi_cnt_n  = CNT_ONE;
                    per_cnt_n = CNT_ONE;
                    valid_n   = 1'b1;
                    if (period_ok && (short_ok || long_ok)) begin
                        is_short_n = short_ok;
                        // streak == 0 means no previous good class to match.
                        if ((streak != '0) && (short_ok == is_short)) begin
                            streak_n = (streak == LOCK_LVL) ? streak : streak + STK_ONE;
                        end else begin
                            streak_n = STK_ONE;
                        end
                        locked_n = (streak_n >= LOCK_LVL);
                    end else begin
                        err_n    = 1'b1;
                        streak_n = '0;
                        locked_n = 1'b0;
                    end
                end else if (per_cnt > PER_MAX) begin
                    state_n   = IDLE;
                    hi_cnt_n  = '0;
                    per_cnt_n = '0;
                    err_n     = 1'b1;
                    streak_n  = '0;
                    locked_n  = 1'b0;
                end else begin
                    per_cnt_n = sat_inc(per_cnt);
                end
            end

            default: begin
                state_n   = IDLE;
                hi_cnt_n  = '0;
                per_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_blink_decoder.sv
// -----------------------------------------------------------------------------
// tb_blink_decoder
//
// Self-checking bench for blink_decoder with small parameters (PERIOD=100,
// LONG_HIGH=50, SHORT_HIGH=25, TOL=2, LOCK_N=2, FILTER_LEN=4). A table of
// periods drives the main classification cases; expected results are queued
// with their due cycle when the closing edge is driven and compared by a
// monitor when the DUT pulses. Hand-written sequences cover timeout, the
// glitch case and reset in the middle of a period.
// -----------------------------------------------------------------------------
module tb_blink_decoder;

    localparam int PERIOD     = 100;
    localparam int LONG_HIGH  = 50;
    localparam int SHORT_HIGH = 25;
    localparam int TOL        = 2;
    localparam int LOCK_N     = 2;
    localparam int FILTER_LEN = 4;

`ifdef BLINK_DECODER_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
    localparam int FLT       = FILTER_LEN;
`else
    localparam bit FILTER_ON = 1'b0;
    localparam int FLT       = 0;
`endif

    // Raw edge driven after posedge c -> result visible after posedge c+LAT.
    localparam int LAT = 3 + FLT;

    typedef struct {
        int   hi;
        int   per;
        logic err;
        logic is_short;
        logic locked;
    } vec_t;

    typedef struct {
        logic valid;
        logic err;
        logic is_short;
        logic locked;
        int   at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic blink_in = 1'b0;
    logic valid, is_short, err, locked;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t pend;
    bit   pend_on = 1'b0;
    logic cur_short = 1'b0;
    logic cur_locked = 1'b0;

    blink_decoder #(
        .PERIOD    (PERIOD),
        .LONG_HIGH (LONG_HIGH),
        .SHORT_HIGH(SHORT_HIGH),
        .TOL       (TOL),
        .LOCK_N    (LOCK_N),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .blink_in(blink_in),
        .valid   (valid),
        .is_short(is_short),
        .err     (err),
        .locked  (locked)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic v, input logic e, input logic s, input logic l, input int at);
        exp_t x;
        x.valid    = v;
        x.err      = e;
        x.is_short = s;
        x.locked   = l;
        x.at       = at;
        sb_q.push_back(x);
    endtask

    task automatic set_pend(input logic v, input logic e, input logic s, input logic l);
        pend.valid    = v;
        pend.err      = e;
        pend.is_short = s;
        pend.locked   = l;
        pend_on       = 1'b1;
    endtask

    task automatic step(input logic v);
        @(posedge clk);
        #1;
        blink_in = v;
    endtask

    // Rising edge; closes the pending period if one is open.
    task automatic rise_close();
        step(1'b1);
        if (pend_on) begin
            pend.at = cyc + LAT;
            sb_q.push_back(pend);
            pend_on = 1'b0;
        end
    endtask

    task automatic play(input int hi, input int per);
        rise_close();
        repeat (hi - 1) step(1'b1);
        repeat (per - hi) step(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    int'(valid),    0);
        check({tag, "_err"},      int'(err),      0);
        check({tag, "_is_short"}, int'(is_short), 0);
        check({tag, "_locked"},   int'(locked),   0);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (valid || err) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", int'({valid, err}), 0);
            end else begin
                e = sb_q.pop_front();
                check("valid",    int'(valid),    int'(e.valid));
                check("err",      int'(err),      int'(e.err));
                check("is_short", int'(is_short), int'(e.is_short));
                check("locked",   int'(locked),   int'(e.locked));
                check("latency",  cyc,            e.at);
                cur_short  = e.is_short;
                cur_locked = e.locked;
            end
        end else begin
            check("hold_is_short", int'(is_short), int'(cur_short));
            check("hold_locked",   int'(locked),   int'(cur_locked));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time budget");
        $fatal(1);
    end

    initial begin
        vec_t vecs [19];
        //          hi  per  err short locked
        vecs[0]  = '{25, 100, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{25, 100, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{25, 100, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{25, 100, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{50, 100, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{50, 100, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{50, 100, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{25, 100, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{25, 100, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{50, 103, 1'b1, 1'b1, 1'b0};  // period one past the bound
        vecs[10] = '{50, 102, 1'b0, 1'b0, 1'b0};  // period at upper bound
        vecs[11] = '{52,  98, 1'b0, 1'b0, 1'b1};  // lower period, upper LONG
        vecs[12] = '{23, 100, 1'b0, 1'b1, 1'b0};  // lower SHORT bound
        vecs[13] = '{27, 100, 1'b0, 1'b1, 1'b1};  // upper SHORT bound
        vecs[14] = '{28, 100, 1'b1, 1'b1, 1'b0};  // just above SHORT
        vecs[15] = '{50,  97, 1'b1, 1'b1, 1'b0};  // period one below bound
        vecs[16] = '{48, 100, 1'b0, 1'b0, 1'b0};  // lower LONG bound
        vecs[17] = '{38, 100, 1'b1, 1'b0, 1'b0};  // between classes
        vecs[18] = '{22, 100, 1'b1, 1'b0, 1'b0};  // just below SHORT

        // Reset state.
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) step(1'b0);

        // Table-driven periods.
        for (int i = 0; i < 19; i++) begin
            play(vecs[i].hi, vecs[i].per);
            set_pend(1'b1, vecs[i].err, vecs[i].is_short, vecs[i].locked);
        end

        // Stuck high: closing edge of the last vector, then a single timeout.
        rise_close();
        push(1'b0, 1'b1, 1'b0, 1'b0, cyc + LAT + PERIOD + TOL + 1);
        repeat (199) step(1'b1);
        repeat (50) step(1'b0);

        // Glitch: 20 high, 1 low, 29 high, 50 low, opened from IDLE.
        rise_close();
        repeat (19) step(1'b1);
        step(1'b0);
        step(1'b1);
        if (!FILTER_ON) push(1'b1, 1'b1, 1'b0, 1'b0, cyc + LAT);
        repeat (28) step(1'b1);
        repeat (50) step(1'b0);
        if (FILTER_ON) set_pend(1'b1, 1'b0, 1'b0, 1'b0);
        else           set_pend(1'b1, 1'b1, 1'b0, 1'b0);

        // Two SHORT periods to reach locked with is_short set.
        play(25, 100);
        set_pend(1'b1, 1'b0, 1'b1, 1'b0);
        play(25, 100);
        set_pend(1'b1, 1'b0, 1'b1, 1'b1);

        // Reset for one cycle in the middle of a high phase.
        rise_close();
        repeat (9) step(1'b1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        blink_in   = 1'b0;
        cur_short  = 1'b0;
        cur_locked = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) step(1'b0);

        // First rising edge after reset only opens a period.
        play(50, 100);
        set_pend(1'b1, 1'b0, 1'b0, 1'b0);
        rise_close();
        repeat (49) step(1'b1);
        repeat (40) step(1'b0);

        check("drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
